// File: rtl/softmax_class_decision_pkg.sv
// Shared definitions for the softmax stage and its class-decision consumer.
package softmax_pkg;

  localparam int unsigned SOFTMAX_NUM_CLASSES = 128;
  localparam int unsigned SOFTMAX_ACTIV_BITS  = 8;
  localparam int unsigned SOFTMAX_IDX_BITS    = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/softmax_class_decision_if.sv
// Vector-in / result-out handshake bundle for the class-decision block.
interface softmax_class_decision_if
  import softmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = SOFTMAX_NUM_CLASSES,
  parameter int unsigned ACTIV_BITS  = SOFTMAX_ACTIV_BITS,
  parameter int unsigned IDX_BITS    = SOFTMAX_IDX_BITS
) ();

  logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in;
  logic                              data_valid;
  logic [ACTIV_BITS-1:0]             threshold;
  logic                              in_ready;
  logic                              overrun;
  logic [IDX_BITS-1:0]               class_idx;
  logic [ACTIV_BITS-1:0]             class_prob;
  logic                              detected;
  logic                              result_valid;
  logic                              result_ready;

  modport master (
    output data_in, data_valid, threshold, result_ready,
    input  in_ready, overrun, class_idx, class_prob, detected, result_valid
  );

  modport slave (
    input  data_in, data_valid, threshold, result_ready,
    output in_ready, overrun, class_idx, class_prob, detected, result_valid
  );

endinterface

// File: rtl/softmax_class_decision_argmax_step.sv
// One argmax compare step: strict greater-than keeps the lowest index on ties.
module argmax_step
  import softmax_pkg::*;
#(
  parameter int unsigned ACTIV_BITS = SOFTMAX_ACTIV_BITS,
  parameter int unsigned IDX_BITS   = SOFTMAX_IDX_BITS
) (
  input  logic [ACTIV_BITS-1:0] elem,
  input  logic [IDX_BITS-1:0]   elem_idx,
  input  logic [ACTIV_BITS-1:0] cur_max,
  input  logic [IDX_BITS-1:0]   cur_idx,
  output logic [ACTIV_BITS-1:0] nxt_max,
  output logic [IDX_BITS-1:0]   nxt_idx
);

  // Take the new element only when it beats the running max.
  always_comb begin
    nxt_max = cur_max;
    nxt_idx = cur_idx;
    if (elem > cur_max) begin
      nxt_max = elem;
      nxt_idx = elem_idx;
    end
  end

endmodule

// File: rtl/softmax_class_decision.sv
// Captures a probability vector, scans it one element per cycle for the
// argmax, and presents index/probability/detect through a valid/ready result.
module softmax_class_decision
  import softmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = SOFTMAX_NUM_CLASSES,
  parameter int unsigned ACTIV_BITS  = SOFTMAX_ACTIV_BITS,
  parameter int unsigned IDX_BITS    = SOFTMAX_IDX_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  softmax_class_decision_if.slave  bus
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

  state_t                            state_q, state_d;
  logic [NUM_CLASSES*ACTIV_BITS-1:0] vec_q;
  logic [ACTIV_BITS-1:0]             thr_q;
  logic [IDX_BITS-1:0]               cnt_q;
  logic [ACTIV_BITS-1:0]             max_q;
  logic [IDX_BITS-1:0]               max_idx_q;

  logic                              capture, scan_last, xfer;
  logic [ACTIV_BITS-1:0]             elem;
  logic [ACTIV_BITS-1:0]             nxt_max;
  logic [IDX_BITS-1:0]               nxt_idx;

  assign elem        = vec_q[32'(cnt_q) * ACTIV_BITS +: ACTIV_BITS];
  assign bus.in_ready = (state_q == ST_IDLE);

  argmax_step #(
    .ACTIV_BITS (ACTIV_BITS),
    .IDX_BITS   (IDX_BITS)
  ) u_step (
    .elem     (elem),
    .elem_idx (cnt_q),
    .cur_max  (max_q),
    .cur_idx  (max_idx_q),
    .nxt_max  (nxt_max),
    .nxt_idx  (nxt_idx)
  );

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    scan_last = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.data_valid) begin
          capture = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cnt_q == LAST_IDX) begin
          scan_last = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.result_ready) begin
          xfer    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture register, scan counter and running max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      thr_q     <= '0;
      cnt_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
    end else if (capture) begin
      vec_q     <= bus.data_in;
      thr_q     <= bus.threshold;
      cnt_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
    end else if (state_q == ST_SCAN) begin
      max_q     <= nxt_max;
      max_idx_q <= nxt_idx;
      // Counter parks on the last index so it never wraps.
      if (!scan_last) cnt_q <= cnt_q + IDX_BITS'(1);
    end
  end

  // Result registers (loaded from the final compare) and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.class_idx    <= '0;
      bus.class_prob   <= '0;
      bus.detected     <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.overrun <= bus.data_valid && (state_q != ST_IDLE);
      if (scan_last) begin
        bus.class_idx    <= nxt_idx;
        bus.class_prob   <= nxt_max;
        bus.detected     <= (nxt_max >= thr_q);
        bus.result_valid <= 1'b1;
      end else if (xfer) begin
        bus.result_valid <= 1'b0;
      end
    end
  end

endmodule
